ddr_ps_calib: RTL and testbench
===============================

# ddr_ps_calib

Read-phase calibration controller for the DDR write/read clock path. It is the initiator side of the `ps_ready`/`ps_up`/`ps_down` handshake exported by `ddr_clkgen`. It sweeps the DCM phase upward from 0 to `STEPS` steps, one read sample per position. It then parks the phase at the centre of the longest passing window and reports the window edges. It sits between `ddr_clkgen` and the read-datapath pattern checker.

## Interface
Parameters:
- `STEPS`, 64, number of increments in the sweep; legal range 1 to 2^`PHASE_W`−2.
- `PHASE_W`, 8, width of the phase position and window registers.
- `SETTLE`, 16, idle cycles after each completed step, before sampling; minimum 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, the same clock as `ddr_clkgen`'s `clk`.
- `reset` in 1: asynchronous, active-high; must be the same net that resets `ddr_clkgen`.
- `start` in 1: one-cycle pulse that begins calibration.
- `ps_ready` in 1: from `ddr_clkgen`; high means a phase step may be requested.
- `ps_up` out 1: phase increment request to `ddr_clkgen`.
- `ps_down` out 1: phase decrement request to `ddr_clkgen`.
- `sample_req` out 1: one-cycle pulse asking the checker to read and compare the pattern.
- `sample_valid` in 1: one-cycle pulse; the checker result is present.
- `sample_ok` in 1: checker result, qualified by `sample_valid`.
- `busy` out 1: calibration in progress.
- `done` out 1: calibration finished; held high until the next accepted `start`.
- `fail` out 1: no passing position found; valid while `done` is high.
- `phase` out `PHASE_W`: current phase position as an unsigned count of steps above the reset phase.
- `win_lo` out `PHASE_W`: first passing position of the chosen window.
- `win_hi` out `PHASE_W`: last passing position of the chosen window.

## Operation
- Reset values: all outputs 0. State is `IDLE`. Internal run and best registers are 0.
- `start` is accepted only in `IDLE` or `DONE`; it is ignored while `busy` is high.
- On an accepted `start`:
  - `done` and `fail` clear and `busy` sets.
  - If `phase`≠0, the block enters `REWIND`, which steps down until `phase`=0.
  - It then enters `SAMPLE`.
- States: `IDLE`, `REWIND`, `STEP`, `WAIT_RDY`, `SETTLE`, `SAMPLE`, `SWAIT`, `CENTER`, `DONE`.
- Step sub-sequence (`STEP`/`WAIT_RDY`), shared by sweep, rewind and centre:
  - `STEP` waits for `ps_ready`=1, then drives `ps_up` (direction up) or `ps_down` (direction down) high.
  - The request stays high until `ps_ready`=0 is sampled. On that cycle the request drops and the state becomes `WAIT_RDY`.
  - `WAIT_RDY` waits for `ps_ready`=1, then `phase` increments or decrements by 1.
  - After `WAIT_RDY`, the block goes to `SETTLE` during the sweep, and back to `REWIND` or `CENTER` otherwise.
  - `ps_up` and `ps_down` are never both high.
- `SETTLE` counts `SETTLE` cycles, then moves to `SAMPLE`.
- `SAMPLE` pulses `sample_req` for one cycle, then moves to `SWAIT`.
- `SWAIT` waits for `sample_valid`. There is no timeout.
  - If `sample_ok`=1: if `cur_len`=0, set `cur_start`=`phase`; then `cur_len`+=1. If `cur_len`(new) > `best_len`, set `best_start`=`cur_start` and `best_len`=`cur_len`(new).
  - If `sample_ok`=0: `cur_len`=0.
  - Strictly-greater replacement means the earliest window wins a tie.
- Leaving `SWAIT`:
  - If `phase`<`STEPS`, go to `STEP` (up).
  - Otherwise, compute `target` = `best_start` + (`best_len`>>1) (floor), set `win_lo`=`best_start` and `win_hi`=`best_start`+`best_len`−1, then go to `CENTER`.
- If `best_len`=0: `target`=0, `fail`=1, and `win_lo`/`win_hi` stay 0.
- `CENTER` steps down while `phase`>`target`. It then enters `DONE`: `busy`=0, `done`=1.
- All arithmetic is unsigned at `PHASE_W` bits. The `STEPS` limit guarantees `best_len` ≤ `STEPS`+1 without overflow.

## Timing
- A step needs a minimum of 3 cycles from `STEP` entry to `ps_up` falling, with `ps_ready` already high and `ddr_clkgen` responding one cycle later.
- `phase` updates on the cycle `ps_ready` is seen high again in `WAIT_RDY`.
- Sample points are exactly positions 0..`STEPS`, giving `STEPS`+1 samples.
- `sample_req` is high for exactly 1 cycle per position.
- An asynchronous `reset` at any point returns the block to `IDLE` with all outputs 0 in the same cycle. `ddr_clkgen` resets with it, so `phase`=0 stays consistent with the DCM.

## Structure
- State encodings, and the `SETTLE`/`STEPS` defaults, go in `ddr_include.v` as defines shared with the rest of the controller.
- One natural sub-module is `ddr_ps_stepper`. It implements the `STEP`/`WAIT_RDY` handshake, with inputs `go` and `dir` and outputs `ps_up`, `ps_down` and a one-cycle `stepped` pulse.

## Test plan
All scenarios use `STEPS`=8 and `SETTLE`=4, with a `ddr_clkgen` behavioural model.

- Pass at positions 2..5 -> 9 `sample_req` pulses, `win_lo`=2, `win_hi`=5, 4 down-steps, `phase`=4, `done`=1, `fail`=0.
- Windows 1..2 and 5..7 -> `win_lo`=5, `win_hi`=7, `phase`=6.
- Tie: windows 0..1 and 4..5 -> `win_lo`=0, `win_hi`=1, `phase`=1.
- All fail -> 8 down-steps, `phase`=0, `done`=1, `fail`=1.
- Model holds `ps_ready` low 20 cycles after a step -> `ps_up` drops one cycle after the low level is sampled, with no second request and no `phase` change until `ps_ready` rises.
- Second `start` from `DONE` at `phase`=4 -> 4 down-steps before the first `sample_req`. Separately, `reset` asserted mid-`SWAIT` -> all outputs 0 immediately, and a later `sample_valid` is ignored.

Source files
------------

// File: rtl/ddr_ps_calib_pkg.sv
// Shared types and defaults for the DDR read-phase calibration controller.
package ddr_ps_calib_pkg;

  localparam int DEF_STEPS   = 64;
  localparam int DEF_PHASE_W = 8;
  localparam int DEF_SETTLE  = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REWIND,
    ST_STEP,
    ST_WAIT_RDY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_SWAIT,
    ST_CENTER,
    ST_DONE
  } cal_state_t;

  typedef enum logic [1:0] {
    STP_IDLE,
    STP_REQ,
    STP_WAIT
  } stp_state_t;

  typedef enum logic [1:0] {
    MODE_SWEEP,
    MODE_REWIND,
    MODE_CENTER
  } step_mode_t;

endpackage

// File: rtl/ddr_ps_calib_stepper.sv
// One phase step over the ps_ready / ps_up / ps_down handshake with ddr_clkgen.
module ddr_ps_calib_stepper
  import ddr_ps_calib_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic dir,
  input  logic ps_ready,
  output logic ps_up,
  output logic ps_down,
  output logic dropped,
  output logic stepped
);

  stp_state_t state, state_nxt;
  logic       req, req_nxt;
  logic       up, up_nxt;

  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    up_nxt    = up;
    dropped   = 1'b0;
    stepped   = 1'b0;
    case (state)
      STP_IDLE: begin
        if (go && ps_ready) begin
          req_nxt   = 1'b1;
          up_nxt    = dir;
          state_nxt = STP_REQ;
        end
      end
      // Request is held until the DCM acknowledges by dropping ready.
      STP_REQ: begin
        if (!ps_ready) begin
          req_nxt   = 1'b0;
          dropped   = 1'b1;
          state_nxt = STP_WAIT;
        end
      end
      STP_WAIT: begin
        if (ps_ready) begin
          stepped   = 1'b1;
          state_nxt = STP_IDLE;
        end
      end
      default: state_nxt = STP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STP_IDLE;
      req   <= 1'b0;
      up    <= 1'b0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      up    <= up_nxt;
    end
  end

  assign ps_up   = req & up;
  assign ps_down = req & ~up;

endmodule

// File: rtl/ddr_ps_calib.sv
// Read-phase calibration: sweep DCM phase 0..STEPS, then park at the centre of the longest passing window.
module ddr_ps_calib
  import ddr_ps_calib_pkg::*;
#(
  parameter int STEPS   = DEF_STEPS,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int SETTLE  = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ps_ready,
  output logic               ps_up,
  output logic               ps_down,
  output logic               sample_req,
  input  logic               sample_valid,
  input  logic               sample_ok,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [PHASE_W-1:0] phase,
  output logic [PHASE_W-1:0] win_lo,
  output logic [PHASE_W-1:0] win_hi
);

  localparam int                 CNT_W   = $clog2(SETTLE + 1);
  localparam logic [PHASE_W-1:0] STEPS_P = PHASE_W'(STEPS);
  localparam logic [PHASE_W-1:0] ONE     = PHASE_W'(1);
  localparam logic [CNT_W-1:0]   SET_END = CNT_W'(SETTLE - 1);

  cal_state_t         state, state_nxt;
  step_mode_t         mode, mode_nxt;
  logic [CNT_W-1:0]   settle_cnt;
  logic [PHASE_W-1:0] cur_start, cur_len, best_start, best_len, target;
  logic [PHASE_W-1:0] sc_start, sc_len, sc_best_start, sc_best_len;
  logic               step_go, step_up, step_dropped, step_stepped;

  assign step_go    = (state == ST_STEP);
  assign step_up    = (mode == MODE_SWEEP);
  assign sample_req = (state == ST_SAMPLE);

  ddr_ps_calib_stepper u_stepper (
    .clk      (clk),
    .reset    (reset),
    .go       (step_go),
    .dir      (step_up),
    .ps_ready (ps_ready),
    .ps_up    (ps_up),
    .ps_down  (ps_down),
    .dropped  (step_dropped),
    .stepped  (step_stepped)
  );

  // Window scoring for the current sample; strictly-greater keeps the earliest window on a tie.
  always_comb begin
    sc_start      = cur_start;
    sc_len        = cur_len;
    sc_best_start = best_start;
    sc_best_len   = best_len;
    if (sample_ok) begin
      if (cur_len == '0) sc_start = phase;
      sc_len = cur_len + ONE;
      if (sc_len > best_len) begin
        sc_best_start = sc_start;
        sc_best_len   = sc_len;
      end
    end else begin
      sc_len = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = (phase != '0) ? ST_REWIND : ST_SAMPLE;
      ST_REWIND: begin
        if (phase != '0) begin
          state_nxt = ST_STEP;
          mode_nxt  = MODE_REWIND;
        end else begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_STEP:     if (step_dropped) state_nxt = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (step_stepped) begin
          case (mode)
            MODE_SWEEP:  state_nxt = ST_SETTLE;
            MODE_REWIND: state_nxt = ST_REWIND;
            default:     state_nxt = ST_CENTER;
          endcase
        end
      end
      ST_SETTLE: if (settle_cnt == SET_END) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = ST_SWAIT;
      ST_SWAIT: begin
        if (sample_valid) begin
          if (phase < STEPS_P) begin
            state_nxt = ST_STEP;
            mode_nxt  = MODE_SWEEP;
          end else begin
            state_nxt = ST_CENTER;
          end
        end
      end
      ST_CENTER: begin
        if (phase > target) begin
          state_nxt = ST_STEP;
          mode_nxt  = MODE_CENTER;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode       <= MODE_SWEEP;
      settle_cnt <= '0;
      phase      <= '0;
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      target     <= '0;
      win_lo     <= '0;
      win_hi     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            target     <= '0;
            win_lo     <= '0;
            win_hi     <= '0;
          end
        end
        ST_WAIT_RDY: begin
          if (step_stepped) begin
            phase      <= step_up ? phase + ONE : phase - ONE;
            settle_cnt <= '0;
          end
        end
        ST_SETTLE: settle_cnt <= settle_cnt + CNT_W'(1);
        ST_SWAIT: begin
          if (sample_valid) begin
            cur_start  <= sc_start;
            cur_len    <= sc_len;
            best_start <= sc_best_start;
            best_len   <= sc_best_len;
            // Last sweep position: pick the park target from the final scores.
            if (phase >= STEPS_P) begin
              if (sc_best_len == '0) begin
                target <= '0;
                fail   <= 1'b1;
              end else begin
                target <= sc_best_start + (sc_best_len >> 1);
                win_lo <= sc_best_start;
                win_hi <= sc_best_start + sc_best_len - ONE;
              end
            end
          end
        end
        ST_CENTER: begin
          if (!(phase > target)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_ps_calib.sv
// Randomized bench for ddr_ps_calib with ddr_clkgen and pattern-checker models.
module tb_ddr_ps_calib;

  localparam int STEPS  = 8;
  localparam int SETTLE = 4;
  localparam int PW     = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          ps_ready = 1'b1;
  logic          sample_valid = 1'b0;
  logic          sample_ok = 1'b0;
  logic          ps_up, ps_down, sample_req, busy, done, fail;
  logic [PW-1:0] phase, win_lo, win_hi;

  always #5 clk = ~clk;

  ddr_ps_calib #(.STEPS(STEPS), .PHASE_W(PW), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ps_ready     (ps_ready),
    .ps_up        (ps_up),
    .ps_down      (ps_down),
    .sample_req   (sample_req),
    .sample_valid (sample_valid),
    .sample_ok    (sample_ok),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .phase        (phase),
    .win_lo       (win_lo),
    .win_hi       (win_hi)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ddr_clkgen model: acknowledges a request by dropping ready for 'hold' cycles.
  int            dcm = 0;
  int            hold = 2;
  int            hold_cnt = 0;
  int            ups = 0;
  int            dns = 0;
  logic [PW-1:0] ph_before = '0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      ps_ready = 1'b1;
      hold_cnt = 0;
      dcm      = 0;
    end else if (hold_cnt > 0) begin
      chk("req_while_busy", {30'd0, ps_up, ps_down}, 0);
      chk("phase_frozen", phase, ph_before);
      hold_cnt--;
      if (hold_cnt == 0) ps_ready = 1'b1;
    end else if (ps_ready && (ps_up || ps_down)) begin
      chk("up_down_excl", ps_up & ps_down, 0);
      ph_before = phase;
      ps_ready  = 1'b0;
      hold_cnt  = hold;
      if (ps_up) begin
        dcm++;
        ups++;
      end else begin
        dcm--;
        dns++;
      end
    end
  end

  // Pattern checker model: answers each sample_req after 1..4 cycles with pat[dcm].
  logic [STEPS:0] pat = '0;
  int             samp_idx = 0;
  int             n_req = 0;
  int             lat = 0;
  int             rewind_dn = -1;
  bit             ok_q = 1'b0;
  bit             prev_req = 1'b0;
  bit             manual = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!manual) begin
      sample_valid = 1'b0;
      sample_ok    = 1'($urandom_range(0, 1));
      if (reset) begin
        lat = 0;
      end else begin
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            sample_valid = 1'b1;
            sample_ok    = ok_q;
          end
        end
        if (sample_req) begin
          chk("sample_pos", dcm, samp_idx);
          samp_idx++;
          n_req++;
          if (rewind_dn < 0) rewind_dn = dns;
          ok_q = pat[dcm];
          lat  = $urandom_range(1, 4);
        end
      end
    end
    if (sample_req) chk("req_one_cycle", prev_req, 0);
    prev_req = sample_req;
  end

  // Reference: brute-force search of all fully passing windows; first longest wins.
  function automatic void ref_model(input logic [STEPS:0] p, output int lo, output int hi,
                                    output int tgt, output bit f);
    int best;
    bit all;
    best = 0;
    lo   = 0;
    hi   = 0;
    for (int a = 0; a <= STEPS; a++) begin
      for (int b = a; b <= STEPS; b++) begin
        all = 1'b1;
        for (int k = a; k <= b; k++) if (!p[k]) all = 1'b0;
        if (all && (b - a + 1) > best) begin
          best = b - a + 1;
          lo   = a;
          hi   = b;
        end
      end
    end
    f   = (best == 0);
    tgt = f ? 0 : lo + best / 2;
  endfunction

  task automatic run_cal(input logic [STEPS:0] p, input int hld, input bit poke_start);
    int lo, hi, tgt, sp, cyc;
    bit f;
    pat       = p;
    hold      = hld;
    ups       = 0;
    dns       = 0;
    n_req     = 0;
    samp_idx  = 0;
    rewind_dn = -1;
    sp        = int'(phase);
    ref_model(p, lo, hi, tgt, f);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {29'd0, busy, done, fail}, 32'd4);
    cyc = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = (poke_start && cyc == 40);
    end
    start = 1'b0;
    chk("done_in_time", done, 1);
    chk("busy_clear", busy, 0);
    chk("fail", fail, f);
    chk("win_lo", win_lo, f ? 0 : lo);
    chk("win_hi", win_hi, f ? 0 : hi);
    chk("phase", phase, tgt);
    chk("sample_count", n_req, STEPS + 1);
    chk("up_steps", ups, STEPS);
    chk("rewind_steps", rewind_dn, sp);
    chk("down_steps", dns, sp + STEPS - tgt);
    chk("dcm_tracks_phase", dcm, phase);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;
    @(negedge clk);
    chk("rst_ctrl", {26'd0, ps_up, ps_down, sample_req, busy, done, fail}, 0);
    chk("rst_phase", phase, 0);
    chk("rst_win", {win_lo, win_hi}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_cal(9'b000111100, 2, 1'b0);  // pass 2..5
    run_cal(9'b011100110, 2, 1'b0);  // 1..2 and 5..7
    run_cal(9'b000110011, 1, 1'b0);  // tie 0..1 / 4..5
    run_cal(9'b000000000, 3, 1'b0);  // all fail
    run_cal(9'b000111100, 20, 1'b0); // slow DCM acknowledge
    run_cal(9'b111111111, 2, 1'b0);  // restart from DONE at phase 4
    for (int i = 0; i < 6; i++) run_cal((STEPS + 1)'($urandom), $urandom_range(1, 3), i == 2);

    // Reset while waiting for a sample result.
    manual       = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!sample_req && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("swait_reached", sample_req, 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ctrl", {26'd0, ps_up, ps_down, sample_req, busy, done, fail}, 0);
    chk("async_rst_phase", phase, 0);
    chk("async_rst_win", {win_lo, win_hi}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_ok    = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || done || sample_req || ps_up || ps_down) seen = 1'b1;
    end
    chk("late_valid_ignored", seen, 0);
    chk("idle_phase", phase, 0);
    manual = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
